alu_operand_issue: RTL and testbench

Operand-issue stage directly upstream of the execute-stage 32-bit adder. It accepts decoded ALU ops from decode under a valid/ready handshake and resolves rs1/rs2 through EX/MEM forwarding. It selects register or immediate for operand B, and converts SUB/CMP into A + ~B + 1 by inverting B and driving carry-in. Results are registered through a 2-entry skid buffer whose outputs connect straight to the adder's `a`, `b` and `cin` inputs.

---
 rtl/alu_operand_issue.sv | 115 +++++++++++
 tb/tb_alu_operand_issue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_issue.sv
// Operand-issue stage feeding the execute adder: resolves rs1/rs2, selects/inverts B, and
// registers {a, b, cin, rd, we} through a 2-entry skid buffer. Optional macro: ALU_OPERAND_FWD_EN.
module alu_operand_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [4:0]      in_rs1_idx,
  input  logic [4:0]      in_rs2_idx,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [4:0]      in_rd,
  input  logic            fwd_ex_we,
  input  logic            fwd_mem_we,
  input  logic [4:0]      fwd_ex_rd,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_ex_data,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic            out_cin,
  output logic [4:0]      out_rd,
  output logic            out_we
);

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_CMP   = 2'b10,
    OP_PASSA = 2'b11
  } op_e;

  // Entry layout: {a, b, cin, rd, we}
  localparam int PW = 2*XLEN + 7;

  logic [XLEN-1:0] rs1_res, rs2_res, b_sel, b_d;
  logic            cin_d, we_d, accept;
  logic [PW-1:0]   entry_d;
  logic [PW-1:0]   main_q, skid_q;
  logic            main_valid_q, skid_valid_q;

  always_comb begin
    rs1_res = in_rs1_val;
    rs2_res = in_rs2_val;
`ifdef ALU_OPERAND_FWD_EN
    // EX is the younger producer, so it overrides MEM.
    if (fwd_ex_we && fwd_ex_rd == in_rs1_idx)        rs1_res = fwd_ex_data;
    else if (fwd_mem_we && fwd_mem_rd == in_rs1_idx) rs1_res = fwd_mem_data;
    if (fwd_ex_we && fwd_ex_rd == in_rs2_idx)        rs2_res = fwd_ex_data;
    else if (fwd_mem_we && fwd_mem_rd == in_rs2_idx) rs2_res = fwd_mem_data;
`endif
    if (in_rs1_idx == 5'd0) rs1_res = '0;
    if (in_rs2_idx == 5'd0) rs2_res = '0;
  end

`ifndef ALU_OPERAND_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{fwd_ex_we, fwd_mem_we, fwd_ex_rd, fwd_mem_rd, fwd_ex_data, fwd_mem_data};
`endif

  assign b_sel = in_use_imm ? in_imm : rs2_res;

  always_comb begin
    b_d   = b_sel;
    cin_d = 1'b0;
    case (op_e'(in_op))
      OP_ADD:         begin b_d = b_sel;  cin_d = 1'b0; end
      OP_SUB, OP_CMP: begin b_d = ~b_sel; cin_d = 1'b1; end
      OP_PASSA:       begin b_d = '0;     cin_d = 1'b0; end
      default:        begin b_d = b_sel;  cin_d = 1'b0; end
    endcase
  end

  assign we_d    = (op_e'(in_op) != OP_CMP) && (in_rd != 5'd0);
  assign entry_d = {rs1_res, b_d, cin_d, in_rd, we_d};

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so no new op competes with the skid transfer.
      if (out_ready) begin
        main_q       <= skid_q;
        skid_valid_q <= 1'b0;
      end
    end else if (!main_valid_q || out_ready) begin
      main_valid_q <= accept;
      if (accept) main_q <= entry_d;
    end else if (accept) begin
      skid_q       <= entry_d;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid = main_valid_q;
  assign {out_a, out_b, out_cin, out_rd, out_we} = main_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue: op encoding, x0 handling, forwarding, backpressure
// ordering, flush and asynchronous reset, against hand-computed expectations.
module tb_alu_operand_issue;

  localparam int XLEN = 32;

  logic            clk, rst_n;
  logic            in_valid, in_ready;
  logic [1:0]      in_op;
  logic [4:0]      in_rs1_idx, in_rs2_idx, in_rd;
  logic [XLEN-1:0] in_rs1_val, in_rs2_val, in_imm;
  logic            in_use_imm;
  logic            fwd_ex_we, fwd_mem_we;
  logic [4:0]      fwd_ex_rd, fwd_mem_rd;
  logic [XLEN-1:0] fwd_ex_data, fwd_mem_data;
  logic            flush;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_a, out_b;
  logic            out_cin, out_we;
  logic [4:0]      out_rd;

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] exp_q[$];

  alu_operand_issue #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
    .fwd_ex_we(fwd_ex_we), .fwd_mem_we(fwd_mem_we),
    .fwd_ex_rd(fwd_ex_rd), .fwd_mem_rd(fwd_mem_rd),
    .fwd_ex_data(fwd_ex_data), .fwd_mem_data(fwd_mem_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_cin(out_cin),
    .out_rd(out_rd), .out_we(out_we)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Driver tasks
  task automatic set_op(input logic [1:0] op, input logic [4:0] rs1_idx, input logic [XLEN-1:0] rs1_val,
                        input logic [4:0] rs2_idx, input logic [XLEN-1:0] rs2_val,
                        input logic [XLEN-1:0] imm, input logic use_imm, input logic [4:0] rd);
    in_op      = op;
    in_rs1_idx = rs1_idx;
    in_rs1_val = rs1_val;
    in_rs2_idx = rs2_idx;
    in_rs2_val = rs2_val;
    in_imm     = imm;
    in_use_imm = use_imm;
    in_rd      = rd;
    in_valid   = 1'b1;
  endtask

  // Issue the op currently on the inputs for one edge, then move to the sampling point.
  task automatic issue_one();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [XLEN-1:0] sum;
  logic            acc;
  int              received;
  int              next_op;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_rs1_idx = '0; in_rs2_idx = '0; in_rs1_val = '0; in_rs2_val = '0;
    in_imm = '0; in_use_imm = 1'b0; in_rd = '0;
    fwd_ex_we = 1'b0; fwd_mem_we = 1'b0; fwd_ex_rd = '0; fwd_mem_rd = '0;
    fwd_ex_data = '0; fwd_mem_data = '0; flush = 1'b0; out_ready = 1'b1;

    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_cin", out_cin, 0);
    check("rst_out_we", out_we, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // ADD 5 + 7
    set_op(2'b00, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 5'd3);
    issue_one();
    check("add_valid", out_valid, 1);
    check("add_a", out_a, 32'd5);
    check("add_b", out_b, 32'd7);
    check("add_cin", out_cin, 0);
    check("add_we", out_we, 1);
    check("add_rd", out_rd, 5'd3);

    // SUB 0x10 - imm 1
    set_op(2'b01, 5'd1, 32'h10, 5'd2, 32'h99, 32'd1, 1'b1, 5'd2);
    issue_one();
    check("sub_b", out_b, 32'hFFFF_FFFE);
    check("sub_cin", out_cin, 1);
    sum = out_a + out_b + {31'd0, out_cin};
    check("sub_sum", sum, 32'h0F);
    check("sub_we", out_we, 1);

    // CMP never writes back
    set_op(2'b10, 5'd4, 32'd9, 5'd5, 32'd3, 32'd0, 1'b0, 5'd5);
    issue_one();
    check("cmp_b", out_b, 32'hFFFF_FFFC);
    check("cmp_cin", out_cin, 1);
    check("cmp_we", out_we, 0);

    // PASSA forces B to zero
    set_op(2'b11, 5'd4, 32'h1234, 5'd5, 32'h55, 32'h77, 1'b1, 5'd6);
    issue_one();
    check("passa_a", out_a, 32'h1234);
    check("passa_b", out_b, 0);
    check("passa_cin", out_cin, 0);
    check("passa_we", out_we, 1);

    // x0 sources read as zero, rd x0 suppresses writeback
    set_op(2'b00, 5'd0, 32'h55, 5'd0, 32'h66, 32'd0, 1'b0, 5'd0);
    issue_one();
    check("x0_a", out_a, 0);
    check("x0_b", out_b, 0);
    check("rd0_we", out_we, 0);

    // Forwarding: EX and MEM both target x3, regfile holds 0xCC
    fwd_ex_we = 1'b1; fwd_ex_rd = 5'd3; fwd_ex_data = 32'hAA;
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hBB;
    set_op(2'b00, 5'd3, 32'hCC, 5'd3, 32'hCC, 32'd0, 1'b0, 5'd7);
    issue_one();
`ifdef ALU_OPERAND_FWD_EN
    check("fwd_ex_a", out_a, 32'hAA);
    check("fwd_ex_b", out_b, 32'hAA);
`else
    check("nofwd_a", out_a, 32'hCC);
    check("nofwd_b", out_b, 32'hCC);
`endif
    fwd_ex_we = 1'b0;
    set_op(2'b00, 5'd3, 32'hCC, 5'd3, 32'hCC, 32'd0, 1'b0, 5'd7);
    issue_one();
`ifdef ALU_OPERAND_FWD_EN
    check("fwd_mem_a", out_a, 32'hBB);
`else
    check("nofwd_mem_a", out_a, 32'hCC);
`endif
    fwd_ex_we = 1'b1; fwd_ex_rd = 5'd0; fwd_mem_we = 1'b0;
    set_op(2'b00, 5'd0, 32'hCC, 5'd0, 32'hCC, 32'd0, 1'b0, 5'd7);
    issue_one();
    check("fwd_x0_a", out_a, 0);
    fwd_ex_we = 1'b0;
    step();

    // Backpressure: op1 held on outputs, op2 into skid, ops 3/4 wait
    exp_q = {32'd1, 32'd2, 32'd3, 32'd4};
    out_ready = 1'b1;
    set_op(2'b00, 5'd1, 32'd1, 5'd0, 32'd0, 32'd0, 1'b0, 5'd4);
    step();
    out_ready = 1'b0;
    set_op(2'b00, 5'd1, 32'd2, 5'd0, 32'd0, 32'd0, 1'b0, 5'd4);
    @(negedge clk);
    check("bp_main_a", out_a, 32'd1);
    check("bp_ready_pre", in_ready, 1);
    step();
    set_op(2'b00, 5'd1, 32'd3, 5'd0, 32'd0, 32'd0, 1'b0, 5'd4);
    @(negedge clk);
    check("bp_hold_a", out_a, 32'd1);
    check("bp_ready_low", in_ready, 0);
    step();
    @(negedge clk);
    check("bp_hold2_a", out_a, 32'd1);
    check("bp_hold2_valid", out_valid, 1);
    step();

    out_ready = 1'b1;
    received  = 0;
    next_op   = 3;
    for (int cyc = 0; cyc < 20 && received < 4; cyc++) begin
      if (next_op <= 4) set_op(2'b00, 5'd1, XLEN'(next_op), 5'd0, 32'd0, 32'd0, 1'b0, 5'd4);
      else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) check("bp_extra", out_a, 32'hDEAD);
        else check("bp_order", out_a, exp_q.pop_front());
        received++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) next_op++;
    end
    in_valid = 1'b0;
    check("bp_count", received, 4);
    @(negedge clk);
    check("bp_drained", out_valid, 0);
    step();

    // Flush with main and skid both full
    out_ready = 1'b0;
    set_op(2'b00, 5'd1, 32'hA1, 5'd0, 32'd0, 32'd0, 1'b0, 5'd4);
    step();
    set_op(2'b00, 5'd1, 32'hA2, 5'd0, 32'd0, 32'd0, 1'b0, 5'd4);
    step();
    flush = 1'b1;
    set_op(2'b00, 5'd1, 32'hA3, 5'd0, 32'd0, 32'd0, 1'b0, 5'd4);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    out_ready = 1'b1;
    set_op(2'b00, 5'd1, 32'hA4, 5'd0, 32'd0, 32'd0, 1'b0, 5'd4);
    issue_one();
    check("post_flush_valid", out_valid, 1);
    check("post_flush_a", out_a, 32'hA4);
    step();

    // Asynchronous reset mid-stall
    out_ready = 1'b0;
    set_op(2'b01, 5'd1, 32'h77, 5'd2, 32'h3, 32'd0, 1'b0, 5'd9);
    step();
    set_op(2'b00, 5'd1, 32'h78, 5'd0, 32'd0, 32'd0, 1'b0, 5'd9);
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_a", out_a, 0);
    check("arst_b", out_b, 0);
    check("arst_cin", out_cin, 0);
    check("arst_rd", out_rd, 0);
    check("arst_we", out_we, 0);
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("arst_discard", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
